led_sdo_rx: RTL and testbench
=============================

Name: led_sdo_rx

Overview:
- Receive-side counterpart of the LED strip serial transmitter: oversamples the cko/sdo pair on one fast clock and recovers each 48-bit LED word (R16,G16,B16, MSB first).
- Delivers per-LED pixel strobes with the 4-bit R/G/B nibbles, counts LEDs per frame and flags framing errors.
- Used as an on-chip loopback checker and as the front end of a cascaded strip controller.

Parameters:
- LED_NUM, 47, LED words expected per frame.
- WORD_W, 48, bits per LED word; three 16-bit channels, payload in the top 4 bits of each.
- IDLE_CYC, 32, clk cycles with no cko rising edge that delimit frames; legal range 4..1023.
- SYNC_STG, 2, synchronizer flops on cko_i and sdo_i; legal range 2..3.

Ports:
- clk, input, 1, sampling clock; must be at least 4x the cko frequency.
- rstn, input, 1, asynchronous active-low reset.
- cko_i, input, 1, serial clock from the strip link; asynchronous to clk.
- sdo_i, input, 1, serial data; valid at the cko rising edge.
- pix_valid, output, 1, one-cycle strobe when a complete LED word is received.
- pix_data, output, 48, full received word; held until the next strobe.
- pix_r / pix_g / pix_b, output, 4 each, pix_data[47:44] / [31:28] / [15:12].
- pix_idx, output, 6, LED index of the current pix_data, 0-based.
- fmt_err, output, 1, sticky per word; asserted with pix_valid if any pad nibble ([43:32],[27:16],[11:0] low 12 bits of each channel) is nonzero.
- frame_busy, output, 1, high while in RX.
- frame_done, output, 1, one-cycle pulse at frame end.
- frame_err, output, 1, valid with frame_done: count mismatch or partial word.
- led_cnt, output, 6, LEDs received in the last completed frame; held until the next frame_done.

Behaviour:
- Input conditioning:
  - cko_i and sdo_i each pass through SYNC_STG flops.
  - A rising edge is detected when sync cko = 1 and its registered copy = 0.
  - The sdo value sampled on the edge cycle is the sync sdo that is aligned in delay with sync cko.
  - The edge is seen SYNC_STG+1 clk cycles after the cko_i rise.
- Idle counter:
  - Cleared on every detected edge; otherwise increments and saturates at IDLE_CYC.
  - idle = (counter == IDLE_CYC).
- FSM states QUIET, IDLE, RX:
  - QUIET is the reset state. It discards edges and moves to IDLE when idle is true. This makes a reset mid-stream resynchronize at the next gap instead of misaligning.
  - IDLE: a detected edge shifts in bit 0 of a new frame and moves to RX; bit count = 1, LED count = 0.
  - RX: each edge shifts sdo into the LSB of a WORD_W shift register (MSB first). When the bit count reaches WORD_W:
    - next cycle: pix_valid = 1 and pix_data = shift register; pix_idx = LED count; fmt_err is evaluated.
    - LED count increments; bit count restarts at 0.
  - RX to IDLE occurs when idle becomes true:
    - frame_done pulses for one cycle; led_cnt = LED count.
    - frame_err = (LED count != LED_NUM) or (bit count != 0). A partial word is discarded and never strobed.
- Overflow: words beyond LED_NUM are not strobed (pix_valid stays low), LED count saturates at LED_NUM+1, and frame_err is set at frame end.
- Simultaneous events: a word completion and idle detection cannot coincide, because idle needs IDLE_CYC cycles after the last edge. The pix_valid for the last word always precedes frame_done by at least IDLE_CYC-1 cycles.
- Reset values: pix_valid, fmt_err, frame_busy, frame_done, frame_err = 0; pix_data = 0; pix_r/g/b = 0; pix_idx = 0; led_cnt = 0; state = QUIET; counters = 0.
- Latency: pix_valid rises SYNC_STG+2 clk cycles after the cko_i rise that carries the 48th bit.

Test Plan:
- Reset, hold cko_i low for 40 clk, then send a 47-word frame at cko period 10 clk.
  - Words have R=0xA000, G=0x5000, B=0xF000, then cko idle 100 clk.
  - Required: 47 pix_valid strobes with pix_r=0xA, pix_g=0x5, pix_b=0xF, pix_idx 0..46, fmt_err=0.
  - Required: one frame_done with led_cnt=47, frame_err=0.
- Frame of 46 words, then idle -> frame_done with led_cnt=46, frame_err=1.
- 47 words plus 20 extra bits, then idle -> 47 strobes, partial word discarded, frame_done with frame_err=1, led_cnt=47.
- Word 3 with G=0x5001 -> pix_valid at idx 3 with fmt_err=1; all other words have fmt_err=0.
- Assert rstn low during bit 17 of word 10, release, stream continues.
  - Required: no pix_valid until after a ≥IDLE_CYC gap.
  - Required: the next full frame is received cleanly with led_cnt=47.
- Run at the minimum ratio (cko period 4 clk) and with a 50-word frame.
  - Required: no bit errors; 47 strobes only; frame_err=1; led_cnt=48 (saturated at LED_NUM+1).

Source files
------------

// File: rtl/led_sdo_rx_if.sv
`timescale 1ns/1ps
// led_sdo_rx_if: serial link inputs and pixel/frame outputs of the LED strip receiver.
// Latency: n/a (wires only).
// Backpressure: none; the receiver drives strobes, the sink must take every one.
// master = receiver side (link in, pixel/frame out); slave = link source plus pixel sink.
interface led_sdo_rx_if;
  logic        cko_i;
  logic        sdo_i;
  logic        pix_valid;
  logic [47:0] pix_data;
  logic [3:0]  pix_r;
  logic [3:0]  pix_g;
  logic [3:0]  pix_b;
  logic [5:0]  pix_idx;
  logic        fmt_err;
  logic        frame_busy;
  logic        frame_done;
  logic        frame_err;
  logic [5:0]  led_cnt;

  modport master (
    input  cko_i, sdo_i,
    output pix_valid, pix_data, pix_r, pix_g, pix_b, pix_idx, fmt_err,
    output frame_busy, frame_done, frame_err, led_cnt
  );

  modport slave (
    output cko_i, sdo_i,
    input  pix_valid, pix_data, pix_r, pix_g, pix_b, pix_idx, fmt_err,
    input  frame_busy, frame_done, frame_err, led_cnt
  );
endinterface

// File: rtl/led_sdo_rx.sv
`timescale 1ns/1ps
// led_sdo_rx: oversamples cko/sdo, recovers 48-bit LED words, strobes pixels, frames on idle gaps.
// Latency: pix_valid rises SYNC_STG+2 clk after the cko_i rise carrying a word's last bit.
// Backpressure: none; pix_valid/frame_done are single-cycle pulses that cannot be stalled.
// Ports: clk (sampling clock, >= 4x cko), rstn (async active low),
//        bus (master): cko_i/sdo_i in; pix_valid/pix_data/pix_r/g/b/pix_idx/fmt_err,
//        frame_busy/frame_done/frame_err/led_cnt out.
module led_sdo_rx #(
  parameter int LED_NUM  = 47,
  parameter int WORD_W   = 48,
  parameter int IDLE_CYC = 32,
  parameter int SYNC_STG = 2
) (
  input  logic         clk,
  input  logic         rstn,
  led_sdo_rx_if.master bus
);

  localparam logic [1:0] ST_QUIET = 2'd0;
  localparam logic [1:0] ST_IDLE  = 2'd1;
  localparam logic [1:0] ST_RX    = 2'd2;

  localparam int IDLE_W = 10;
  localparam int BIT_W  = $clog2(WORD_W + 1);
  localparam int CNT_W  = 6;

  // Input conditioning
  logic [SYNC_STG-1:0] cko_sync_q, cko_sync_d;
  logic [SYNC_STG-1:0] sdo_sync_q, sdo_sync_d;
  logic                cko_dly_q, cko_dly_d;
  logic                cko_s, sdo_s, cko_rise;

  // Idle gap detection
  logic [IDLE_W-1:0]   idle_cnt_q, idle_cnt_d;
  logic                idle;

  // Receive state
  logic [1:0]          state_q, state_d;
  logic [BIT_W-1:0]    bit_cnt_q, bit_cnt_d;
  logic [CNT_W-1:0]    rx_cnt_q, rx_cnt_d;
  logic [WORD_W-1:0]   shift_q, shift_d;
  logic                word_full;

  // Output registers
  logic                pix_valid_q, pix_valid_d;
  logic [WORD_W-1:0]   pix_data_q, pix_data_d;
  logic [CNT_W-1:0]    pix_idx_q, pix_idx_d;
  logic                fmt_err_q, fmt_err_d;
  logic                frame_done_q, frame_done_d;
  logic                frame_err_q, frame_err_d;
  logic [CNT_W-1:0]    led_cnt_q, led_cnt_d;

  // sdo runs through an identical chain so the sampled bit stays aligned with the detected edge.
  always_comb begin
    cko_sync_d = {cko_sync_q[SYNC_STG-2:0], bus.cko_i};
    sdo_sync_d = {sdo_sync_q[SYNC_STG-2:0], bus.sdo_i};
    cko_s      = cko_sync_q[SYNC_STG-1];
    sdo_s      = sdo_sync_q[SYNC_STG-1];
    cko_dly_d  = cko_s;
    cko_rise   = cko_s & ~cko_dly_q;
  end

  always_comb begin
    idle = (idle_cnt_q == IDLE_W'(IDLE_CYC));
    if (cko_rise) begin
      idle_cnt_d = '0;
    end else if (idle) begin
      idle_cnt_d = idle_cnt_q;
    end else begin
      idle_cnt_d = idle_cnt_q + IDLE_W'(1);
    end
  end

  always_comb begin
    state_d      = state_q;
    bit_cnt_d    = bit_cnt_q;
    rx_cnt_d     = rx_cnt_q;
    shift_d      = shift_q;
    pix_valid_d  = 1'b0;
    pix_data_d   = pix_data_q;
    pix_idx_d    = pix_idx_q;
    fmt_err_d    = fmt_err_q;
    frame_done_d = 1'b0;
    frame_err_d  = frame_err_q;
    led_cnt_d    = led_cnt_q;

    // A full word is handed out one cycle after its last bit was shifted in.
    word_full = (state_q == ST_RX) && (bit_cnt_q == BIT_W'(WORD_W));
    if (word_full) begin
      bit_cnt_d = '0;
      if (rx_cnt_q < CNT_W'(LED_NUM)) begin
        pix_valid_d = 1'b1;
        pix_data_d  = shift_q;
        pix_idx_d   = rx_cnt_q;
        fmt_err_d   = |{shift_q[43:32], shift_q[27:16], shift_q[11:0]};
      end
      // Saturate one past LED_NUM so an overlong frame is still distinguishable.
      if (rx_cnt_q <= CNT_W'(LED_NUM)) begin
        rx_cnt_d = rx_cnt_q + CNT_W'(1);
      end
    end

    case (state_q)
      ST_QUIET: begin
        // Edges before the first gap belong to a frame we joined mid-stream.
        if (idle) begin
          if (cko_rise) begin
            state_d   = ST_RX;
            shift_d   = {{(WORD_W-1){1'b0}}, sdo_s};
            bit_cnt_d = BIT_W'(1);
            rx_cnt_d  = '0;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end

      ST_IDLE: begin
        if (cko_rise) begin
          state_d   = ST_RX;
          shift_d   = {{(WORD_W-1){1'b0}}, sdo_s};
          bit_cnt_d = BIT_W'(1);
          rx_cnt_d  = '0;
        end
      end

      ST_RX: begin
        if (idle) begin
          frame_done_d = 1'b1;
          led_cnt_d    = rx_cnt_q;
          frame_err_d  = (rx_cnt_q != CNT_W'(LED_NUM)) || (bit_cnt_q != '0);
          // An edge landing exactly on the gap boundary opens the next frame.
          if (cko_rise) begin
            shift_d   = {{(WORD_W-1){1'b0}}, sdo_s};
            bit_cnt_d = BIT_W'(1);
            rx_cnt_d  = '0;
          end else begin
            state_d = ST_IDLE;
          end
        end else if (cko_rise) begin
          shift_d   = {shift_q[WORD_W-2:0], sdo_s};
          bit_cnt_d = bit_cnt_d + BIT_W'(1);
        end
      end

      default: state_d = ST_QUIET;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cko_sync_q   <= '0;
      sdo_sync_q   <= '0;
      cko_dly_q    <= 1'b0;
      idle_cnt_q   <= '0;
      state_q      <= ST_QUIET;
      bit_cnt_q    <= '0;
      rx_cnt_q     <= '0;
      shift_q      <= '0;
      pix_valid_q  <= 1'b0;
      pix_data_q   <= '0;
      pix_idx_q    <= '0;
      fmt_err_q    <= 1'b0;
      frame_done_q <= 1'b0;
      frame_err_q  <= 1'b0;
      led_cnt_q    <= '0;
    end else begin
      cko_sync_q   <= cko_sync_d;
      sdo_sync_q   <= sdo_sync_d;
      cko_dly_q    <= cko_dly_d;
      idle_cnt_q   <= idle_cnt_d;
      state_q      <= state_d;
      bit_cnt_q    <= bit_cnt_d;
      rx_cnt_q     <= rx_cnt_d;
      shift_q      <= shift_d;
      pix_valid_q  <= pix_valid_d;
      pix_data_q   <= pix_data_d;
      pix_idx_q    <= pix_idx_d;
      fmt_err_q    <= fmt_err_d;
      frame_done_q <= frame_done_d;
      frame_err_q  <= frame_err_d;
      led_cnt_q    <= led_cnt_d;
    end
  end

  always_comb begin
    bus.pix_valid  = pix_valid_q;
    bus.pix_data   = pix_data_q;
    bus.pix_r      = pix_data_q[47:44];
    bus.pix_g      = pix_data_q[31:28];
    bus.pix_b      = pix_data_q[15:12];
    bus.pix_idx    = pix_idx_q;
    bus.fmt_err    = fmt_err_q;
    bus.frame_busy = (state_q == ST_RX);
    bus.frame_done = frame_done_q;
    bus.frame_err  = frame_err_q;
    bus.led_cnt    = led_cnt_q;
  end

endmodule

// File: tb/tb_led_sdo_rx.sv
`timescale 1ns/1ps
// tb_led_sdo_rx: drives framed LED words over cko/sdo and checks strobes and framing.
// Latency: n/a (testbench).
// Backpressure: n/a; every strobe and frame pulse is captured by a monitor.
module tb_led_sdo_rx;
  localparam int LED_NUM  = 47;
  localparam int WORD_W   = 48;
  localparam int IDLE_CYC = 32;
  localparam int SYNC_STG = 2;
  localparam logic [47:0] PAD_MASK = 48'h0FFF_0FFF_0FFF;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  int   cyc = 0;
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  led_sdo_rx_if bus ();

  led_sdo_rx #(
    .LED_NUM(LED_NUM), .WORD_W(WORD_W), .IDLE_CYC(IDLE_CYC), .SYNC_STG(SYNC_STG)
  ) dut (
    .clk(clk),
    .rstn(rstn),
    .bus(bus.master)
  );

  typedef struct {
    logic [47:0] d;
    logic [5:0]  idx;
    logic        fe;
    logic [3:0]  r, g, b;
    int          cyc;
  } strobe_t;

  typedef struct {
    logic [5:0] cnt;
    logic       err;
  } frm_t;

  strobe_t     sq[$];
  frm_t        fq[$];
  int          rise_q[$];
  logic [47:0] tx_words[$];
  strobe_t     ms;
  frm_t        mf;

  // Monitor: capture every pulse away from the active edge.
  always @(negedge clk) begin
    if (bus.pix_valid) begin
      ms.d = bus.pix_data; ms.idx = bus.pix_idx; ms.fe = bus.fmt_err;
      ms.r = bus.pix_r; ms.g = bus.pix_g; ms.b = bus.pix_b; ms.cyc = cyc;
      sq.push_back(ms);
    end
    if (bus.frame_done) begin
      mf.cnt = bus.led_cnt; mf.err = bus.frame_err;
      fq.push_back(mf);
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [47:0] mk(input logic [3:0] r, input logic [3:0] g, input logic [3:0] b);
    return {r, 12'h000, g, 12'h000, b, 12'h000};
  endfunction

  function automatic logic [47:0] rnd_word();
    return mk(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
  endfunction

  task automatic chk_reset(input string tag);
    chk({tag, "_pix_valid"}, bus.pix_valid, 0);
    chk({tag, "_pix_data"}, bus.pix_data, 0);
    chk({tag, "_pix_rgb"}, {bus.pix_r, bus.pix_g, bus.pix_b}, 0);
    chk({tag, "_pix_idx"}, bus.pix_idx, 0);
    chk({tag, "_flags"}, {bus.fmt_err, bus.frame_busy, bus.frame_done, bus.frame_err}, 0);
    chk({tag, "_led_cnt"}, bus.led_cnt, 0);
  endtask

  task automatic gap(input int n);
    bus.cko_i = 1'b0;
    bus.sdo_i = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b, input int period, input bit last);
    bus.cko_i = 1'b0;
    bus.sdo_i = b;
    repeat (period / 2) @(posedge clk);
    #1;
    bus.cko_i = 1'b1;
    if (last) rise_q.push_back(cyc);
    repeat (period - period / 2) @(posedge clk);
    #1;
  endtask

  // Sends tx_words MSB first, then extra random bits; optionally pulses reset at one bit.
  task automatic send_frame(input int extra, input int period, input int rst_word, input int rst_bit);
    logic [47:0] w;
    for (int wi = 0; wi < tx_words.size(); wi++) begin
      w = tx_words[wi];
      for (int bi = 0; bi < WORD_W; bi++) begin
        if (wi == rst_word && bi == rst_bit) begin
          rstn = 1'b0;
          @(posedge clk);
          #1;
          chk_reset("rst_mid");
          rstn = 1'b1;
        end
        send_bit(w[47 - bi], period, bi == WORD_W - 1);
      end
    end
    for (int k = 0; k < extra; k++) send_bit(1'($urandom_range(0, 1)), period, 1'b0);
  endtask

  task automatic start_capture();
    sq.delete();
    fq.delete();
    rise_q.delete();
  endtask

  // Reference: the first nstrobe words of tx_words in order, then the frame summary.
  task automatic check_frame(input string tag, input int nstrobe, input int ndone,
                             input int cnt, input bit err);
    logic [47:0] w;
    chk({tag, "_nstrobe"}, sq.size(), nstrobe);
    for (int i = 0; i < nstrobe && i < sq.size(); i++) begin
      w = tx_words[i];
      chk($sformatf("%s_w%0d_data", tag, i), sq[i].d, w);
      chk($sformatf("%s_w%0d_idx", tag, i), sq[i].idx, i);
      chk($sformatf("%s_w%0d_fmt", tag, i), sq[i].fe, (w & PAD_MASK) != 48'h0);
      chk($sformatf("%s_w%0d_rgb", tag, i), {sq[i].r, sq[i].g, sq[i].b},
          {4'(w >> 44), 4'(w >> 28), 4'(w >> 12)});
    end
    chk({tag, "_ndone"}, fq.size(), ndone);
    for (int i = 0; i < fq.size() && i < ndone; i++) begin
      chk({tag, "_led_cnt"}, fq[i].cnt, cnt);
      chk({tag, "_frame_err"}, fq[i].err, err);
    end
  endtask

  initial begin
    bus.cko_i = 1'b0;
    bus.sdo_i = 1'b0;
    rstn = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_reset("rst0");
    rstn = 1'b1;
    gap(40);

    // Nominal frame at cko period 10
    tx_words.delete();
    for (int i = 0; i < LED_NUM; i++) tx_words.push_back(mk(4'hA, 4'h5, 4'hF));
    start_capture();
    send_frame(0, 10, -1, -1);
    chk("f1_busy", bus.frame_busy, 1);
    gap(100);
    chk("f1_busy_after", bus.frame_busy, 0);
    check_frame("f1", 47, 1, 47, 1'b0);
    chk("f1_latency", (sq.size() > 0 && rise_q.size() > 0) ? sq[0].cyc - rise_q[0] : -1,
        SYNC_STG + 2);

    // Short frame of 46 random words
    tx_words.delete();
    for (int i = 0; i < 46; i++) tx_words.push_back(rnd_word());
    start_capture();
    send_frame(0, 4, -1, -1);
    gap(100);
    check_frame("f2", 46, 1, 46, 1'b1);

    // 47 words + 20 stray bits, word 3 carries a nonzero pad in G
    tx_words.delete();
    for (int i = 0; i < LED_NUM; i++) tx_words.push_back(rnd_word());
    tx_words[3] = mk(4'($urandom_range(0, 15)), 4'h5, 4'($urandom_range(0, 15))) | (48'h1 << 16);
    start_capture();
    send_frame(20, 4, -1, -1);
    gap(100);
    check_frame("f3", 47, 1, 47, 1'b1);

    // Reset during bit 17 of word 10; the rest of the stream must be ignored
    tx_words.delete();
    for (int i = 0; i < 13; i++) tx_words.push_back(rnd_word());
    start_capture();
    send_frame(0, 4, 10, 17);
    gap(100);
    check_frame("f4", 10, 0, 0, 1'b0);

    // Clean frame after resynchronisation
    tx_words.delete();
    for (int i = 0; i < LED_NUM; i++) tx_words.push_back(rnd_word());
    start_capture();
    send_frame(0, 4, -1, -1);
    gap(100);
    check_frame("f5", 47, 1, 47, 1'b0);

    // Overlong 50-word frame at the minimum ratio
    tx_words.delete();
    for (int i = 0; i < 50; i++) tx_words.push_back(rnd_word());
    start_capture();
    send_frame(0, 4, -1, -1);
    gap(100);
    check_frame("f6", 47, 1, 48, 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
